// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   state_e         scanner FSM states (SCAN, DEBOUNCE, HELD)
//   ROW_IDLE        row drive value after reset (row 0 driven low)
//   COL_NONE        column pattern with no key pressed (all pulled up)
//   NUM_ROWS/COLS   matrix geometry
//   KEY_W           key code width (row * 4 + col)
//   lowest_low_col  index of the lowest active-low column in a pattern
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  localparam logic [NUM_ROWS-1:0] ROW_IDLE = 4'b1110;
  localparam logic [NUM_COLS-1:0] COL_NONE = 4'hF;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  // Several keys in one row may be low together; the lowest column wins.
  function automatic logic [1:0] lowest_low_col(input logic [NUM_COLS-1:0] pat);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!pat[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: two-flop synchronizer for the asynchronous column inputs.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset (flops reset to COL_NONE)
//   d_in    in  W-bit asynchronous input
//   d_sync  out W-bit synchronized output, two clocks of latency
module keypad_sync
  import keypad_pkg::*;
#(
  parameter int W = NUM_COLS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_sync
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  // Reset to "no key" so a reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= W'(COL_NONE);
      sync_q <= W'(COL_NONE);
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign d_sync = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix one row at a time,
// debounces presses and releases, and reports each accepted key.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   COL[3:0]   in   matrix columns, active-low, asynchronous to clk
//   ROW[3:0]   out  matrix rows, active-low, exactly one bit low
//   key_valid  out  one-cycle strobe when a key is accepted (or repeats)
//   key_code   out  row*4+col of the accepted key, held until next accept
//   key_held   out  high while the accepted key remains pressed
// Strobe semantics: key_valid is a pure strobe with no back-pressure; a
// consumer must take key_code in the cycle key_valid is high. It never stays
// high two cycles in a row because decisions happen only at slot samples.
// Optional feature: define KEYPAD_REPEAT_EN for auto-repeat while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV         = 1000,
  parameter int unsigned DEBOUNCE_SAMPLES = 8,
  parameter int unsigned REPEAT_DELAY     = 250,
  parameter int unsigned REPEAT_RATE      = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       COL,
  output logic [3:0]       ROW,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  output logic             key_held
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam int ROW_W = $clog2(NUM_ROWS);

  logic [NUM_COLS-1:0] col_s;

  logic [CNT_W-1:0]    slot_cnt_q, slot_cnt_d;
  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_idx_q, row_idx_d;
  logic [NUM_COLS-1:0] pat_q, pat_d;
  logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
  logic [DEB_W-1:0]    rel_cnt_q, rel_cnt_d;
  logic                key_valid_q, key_valid_d;
  logic [KEY_W-1:0]    key_code_q, key_code_d;
  logic                key_held_q, key_held_d;

  logic                sample;
  logic [DEB_W-1:0]    deb_inc;
  logic [DEB_W-1:0]    rel_inc;
  logic                rep_fire;

  keypad_sync #(.W(NUM_COLS)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_in   (COL),
    .d_sync (col_s)
  );

  // Columns are looked at once per row slot, on its last clock, so the
  // row drive has settled for the whole slot before the decision.
  assign sample  = (slot_cnt_q == CNT_W'(SCAN_DIV - 1));
  assign deb_inc = deb_cnt_q + DEB_W'(1);
  assign rel_inc = rel_cnt_q + DEB_W'(1);

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
  logic             rep_phase_q, rep_phase_d;

  assign rep_inc = rep_cnt_q + REP_W'(1);

  // rep_phase_q=0: waiting out the initial delay; 1: periodic repeats.
  // A release sample stops repeating and re-arms the initial delay.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    rep_fire    = 1'b0;
    if (state_q != HELD) begin
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
    end else if (sample) begin
      if (col_s == COL_NONE) begin
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
      end else if (rep_inc == (rep_phase_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY))) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = '0;
        rep_phase_d = 1'b1;
      end else begin
        rep_cnt_d = rep_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  // Repeat timing has no effect in this build.
  logic unused_rep_cfg;
  assign unused_rep_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
  assign rep_fire       = 1'b0;
`endif

  always_comb begin
    slot_cnt_d  = sample ? '0 : slot_cnt_q + CNT_W'(1);
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    pat_d       = pat_q;
    deb_cnt_d   = deb_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;

    if (sample) begin
      unique case (state_q)
        SCAN: begin
          if (col_s == COL_NONE) begin
            row_idx_d = row_idx_q + ROW_W'(1);
          end else begin
            // Freeze the row and remember which columns were low.
            pat_d     = col_s;
            deb_cnt_d = DEB_W'(1);
            state_d   = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (col_s == pat_q) begin
            if (deb_inc == DEB_W'(DEBOUNCE_SAMPLES)) begin
              key_valid_d = 1'b1;
              key_code_d  = {row_idx_q, lowest_low_col(pat_q)};
              key_held_d  = 1'b1;
              deb_cnt_d   = '0;
              rel_cnt_d   = '0;
              state_d     = HELD;
            end else begin
              deb_cnt_d = deb_inc;
            end
          end else begin
            deb_cnt_d = '0;
            row_idx_d = row_idx_q + ROW_W'(1);
            state_d   = SCAN;
          end
        end
        HELD: begin
          // Only all-released samples count; any low column (even a
          // different one) restarts the release count without a new code.
          if (col_s == COL_NONE) begin
            if (rel_inc == DEB_W'(DEBOUNCE_SAMPLES)) begin
              key_held_d = 1'b0;
              rel_cnt_d  = '0;
              row_idx_d  = row_idx_q + ROW_W'(1);
              state_d    = SCAN;
            end else begin
              rel_cnt_d = rel_inc;
            end
          end else begin
            rel_cnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    key_valid_d = key_valid_d | rep_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q  <= '0;
      state_q     <= SCAN;
      row_idx_q   <= '0;
      pat_q       <= COL_NONE;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      pat_q       <= pat_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
    end
  end

  // One-hot-low row drive; row_idx 0 gives ROW_IDLE.
  assign ROW       = ~((~ROW_IDLE) << row_idx_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a behavioural
// key matrix (pressed keys pull their column low while their row is driven).
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV         = 4;
  localparam int unsigned DEBOUNCE_SAMPLES = 3;
  localparam int unsigned REPEAT_DELAY     = 5;
  localparam int unsigned REPEAT_RATE      = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic       prev_valid = 1'b0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  exp_row;
    logic        exp_valid;
    logic        exp_held;
  } vec_t;

  vec_t vecs[16];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Key matrix: key r*4+c connects row r to column c.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
      end
    end
  end

  keypad_scanner #(
    .SCAN_DIV         (SCAN_DIV),
    .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
    .REPEAT_DELAY     (REPEAT_DELAY),
    .REPEAT_RATE      (REPEAT_RATE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .COL       (col),
    .ROW       (row),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every key_valid must match the next expected code; never two in a row.
  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      logic [3:0] exp;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key_valid: got code %0d, none expected", key_code);
      end else begin
        exp = exp_q.pop_front();
        if (key_code !== exp) begin
          errors++;
          $display("FAIL scoreboard_code: got %0d expected %0d", key_code, exp);
        end
      end
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_back_to_back: got 2 consecutive strobes expected 1");
      end
    end
    prev_valid = rst_n & key_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < budget && !seen) begin
      tick();
      n++;
      if (key_valid) seen = 1'b1;
    end
  endtask

  task automatic wait_release(input int budget, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < budget && !seen) begin
      tick();
      n++;
      if (!key_held) seen = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  n;
    bit  seen;
    int  cnt;
    int  changes;
    logic [3:0] last_row;
    logic [3:0] row_seq[4];
    logic exp_v;

    row_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    // Entry i is checked after i+1 clocks out of reset; rows change every 4.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{16'h0000, row_seq[((i + 1) / 4) % 4], 1'b0, 1'b0};
    end

    keys  = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // 1: reset state and idle scan
    check("reset_row", row, 4'b1110);
    check("reset_valid", key_valid, 1'b0);
    check("reset_code", key_code, 4'd0);
    check("reset_held", key_held, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      keys = vecs[i].keys;
      tick();
      check($sformatf("scan_row[%0d]", i), row, vecs[i].exp_row);
      check($sformatf("scan_valid[%0d]", i), key_valid, vecs[i].exp_valid);
      check($sformatf("scan_held[%0d]", i), key_held, vecs[i].exp_held);
    end

    // 2: row2/col1 press and release
    exp_q.push_back(4'd9);
    keys = 16'h0200;
    wait_valid(100, n, seen);
    check("press9_seen", seen, 1'b1);
    check("press9_code", key_code, 4'd9);
    check("press9_held", key_held, 1'b1);
    tick();
    check("press9_strobe_len", key_valid, 1'b0);
    cnt = 0;
    repeat (10) begin
      tick();
      if (key_valid) cnt++;
    end
    check("press9_single", cnt, 0);
    keys = 16'h0000;
    wait_release(30, n, seen);
    check("release9_seen", seen, 1'b1);
    check("release9_latency_ok", (n >= 11 && n <= 14), 1'b1);
    check("release9_row3", row, 4'b0111);
    check("release9_code_kept", key_code, 4'd9);

    // 3: single-sample bounce on column 1 (every row), then released
    keys = 16'h2222;
    repeat (4) tick();
    keys = 16'h0000;
    cnt = 0;
    changes = 0;
    last_row = row;
    repeat (24) begin
      tick();
      if (key_valid) cnt++;
      if (row != last_row) changes++;
      last_row = row;
    end
    check("bounce_no_valid", cnt, 0);
    check("bounce_no_held", key_held, 1'b0);
    check("bounce_row_moves", (changes >= 4), 1'b1);

    // 4: two keys in row1 -> lowest column; row3 key ignored while held
    exp_q.push_back(4'd5);
    keys = 16'h00A0;
    wait_valid(100, n, seen);
    check("multi_seen", seen, 1'b1);
    check("multi_code", key_code, 4'd5);
    keys = keys | 16'h4000;
    cnt = 0;
    repeat (12) begin
      tick();
      if (key_valid) cnt++;
    end
    check("other_row_ignored", cnt, 0);
    check("multi_row_frozen", row, 4'b1101);
    check("multi_code_kept", key_code, 4'd5);
    check("multi_held", key_held, 1'b1);
    keys = 16'h0000;
    wait_release(30, n, seen);
    check("multi_release_seen", seen, 1'b1);

    // 5: asynchronous reset while held, key stays pressed
    exp_q.push_back(4'd9);
    keys = 16'h0200;
    wait_valid(100, n, seen);
    check("pre_reset_seen", seen, 1'b1);
    check("pre_reset_held", key_held, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_row", row, 4'b1110);
    check("async_reset_valid", key_valid, 1'b0);
    check("async_reset_code", key_code, 4'd0);
    check("async_reset_held", key_held, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'd9);
    wait_valid(40, n, seen);
    check("redetect_seen", seen, 1'b1);
    check("redetect_latency", n, 20);
    check("redetect_code", key_code, 4'd9);
    tick();
    check("redetect_strobe_len", key_valid, 1'b0);
    keys = 16'h0000;
    wait_release(30, n, seen);
    check("redetect_release", seen, 1'b1);

    // 6: hold row0/col0 from reset; repeats only with KEYPAD_REPEAT_EN
    rst_n = 1'b0;
    keys  = 16'h0001;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`ifdef KEYPAD_REPEAT_EN
    repeat (5) exp_q.push_back(4'd0);
`else
    exp_q.push_back(4'd0);
`endif
    for (int p = 1; p <= 60; p++) begin
      tick();
`ifdef KEYPAD_REPEAT_EN
      exp_v = (p == 12 || p == 32 || p == 40 || p == 48 || p == 56);
`else
      exp_v = (p == 12);
`endif
      check($sformatf("hold0_valid[p=%0d]", p), key_valid, exp_v);
    end
    check("hold0_code", key_code, 4'd0);
    check("hold0_held", key_held, 1'b1);
    keys = 16'h0000;
    wait_release(30, n, seen);
    check("hold0_release", seen, 1'b1);

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
